// File: rtl/fetch_prefetch.sv
// fetch_prefetch
//   Instruction fetch stage with an in-order prefetch queue feeding decode.
//   Owns the fetch PC, issues word requests to a pipelined instruction memory
//   (req/gnt, in-order rvalid), buffers returned words with their PCs and
//   presents them through a valid/ready handshake. A redirect flushes the
//   queue and arranges for stale in-flight responses to be dropped.
// Ports
//   clk, rst                 clock, async active-low reset
//   imem_req/addr/gnt        request channel (req & gnt = issued)
//   imem_rvalid/rdata        in-order response channel
//   redirect/redirect_pc     flush and restart fetch at redirect_pc
//   instr_valid/instr/pc     queue head to the core
//   instr_ready              core accepts head (valid & ready = pop)
module fetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
    localparam logic [CW-1:0] FULL_C  = DEPTH[CW-1:0];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t          q_mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, outstanding, discard, outstanding_nxt;
    logic [31:0]     fetch_pc, resp_pc, redirect_al;
    logic [CW:0]     credit_used;
    logic            issue, push, pop;

    // Every queue slot is reserved at issue time: buffered + in-flight never
    // exceeds DEPTH, so a response always has room when it lands.
    assign credit_used     = {1'b0, count} + {1'b0, outstanding};
    assign imem_req        = rst & ~redirect & (credit_used < DEPTH_W);
    assign imem_addr       = fetch_pc;
    assign issue           = imem_req & imem_gnt;
    assign pop             = instr_valid & instr_ready;
    // Words arriving while a redirect is sampled belong to the old path.
    assign push            = imem_rvalid & (discard == '0) & ~redirect;
    assign outstanding_nxt = outstanding + CW'(issue) - CW'(imem_rvalid);
    assign redirect_al     = {redirect_pc[31:2], 2'b00};

    assign head        = q_mem[rd_ptr];
    assign instr_valid = (count != '0);
    // Gate the head so stale/uninitialised storage never reaches the core.
    assign instr       = instr_valid ? head.word : '0;
    assign instr_pc    = instr_valid ? head.pc   : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                // Everything still in flight after this cycle is stale.
                fetch_pc <= redirect_al;
                resp_pc  <= redirect_al;
                discard  <= outstanding_nxt;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rvalid) begin
                    if (discard != '0) discard <= discard - CW'(1);
                    else               resp_pc <= resp_pc + 32'd4;
                end
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= '{pc: resp_pc, word: imem_rdata};
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && count == FULL_C));
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst)
        outstanding <= FULL_C);

endmodule
